// File: rtl/f2i_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : f2i_share_arbiter
// Description : Shares one external float_to_int8 converter between N_REQ
//               requesters. Round-robin arbitration, credit-based issue, a
//               CVT_LAT-deep tag pipeline and a FWFT output FIFO per lane.
//               Optional macro F2I_ARB_PRIO0_EN gives lane 0 strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module f2i_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CVT_LAT   = 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N_REQ*32-1:0] req_data,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  output logic [31:0]         cvt_din,
  output logic                cvt_din_valid,
  input  logic [7:0]          cvt_dout,
  input  logic                cvt_dout_valid,
  output logic [N_REQ*8-1:0]  res_data,
  output logic [N_REQ-1:0]    res_valid,
  input  logic [N_REQ-1:0]    res_ready,
  output logic                err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   cand;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    idx;
  logic               found;
  logic               issue;
  logic               ptr_adv;
  logic [ID_W-1:0]    rr_ptr;

  logic [CVT_LAT-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [CVT_LAT];
  logic               wb_v;
  logic [ID_W-1:0]    wb_id;

  // Circular increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pick one eligible lane, searching from the round-robin pointer.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    cand  = elig;
    idx   = rr_ptr;
`ifdef F2I_ARB_PRIO0_EN
    if (elig[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
    cand[0] = 1'b0;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && cand[idx]) begin
        grant[idx] = 1'b1;
        gid        = idx;
        found      = 1'b1;
      end
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
    // No handshakes may complete while the block is held in reset.
    if (!nrst) grant = '0;
  end

  assign issue         = |grant;
  assign req_ready     = grant;
  assign cvt_din_valid = issue;

`ifdef F2I_ARB_PRIO0_EN
  // Lane-0 wins bypass the rotation, so they leave the pointer alone.
  assign ptr_adv = issue && !grant[0];
`else
  assign ptr_adv = issue;
`endif

  // Forward the granted lane's operand; zero when nothing is issued.
  always_comb begin
    cvt_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) cvt_din = req_data[i*32 +: 32];
    end
  end

  // Advance the rotation past the lane just served.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr <= '0;
    end else if (ptr_adv) begin
      rr_ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
    end
  end

  // Tag shift register tracking which lane owns each converter slot.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tag_v <= '0;
      for (int s = 0; s < CVT_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= gid;
      for (int s = 1; s < CVT_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign wb_v  = cvt_dout_valid && tag_v[CVT_LAT-1];
  assign wb_id = tag_id[CVT_LAT-1];

  // Sticky flag for any converter strobe that disagrees with the tag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err <= 1'b0;
    end else if (cvt_dout_valid != tag_v[CVT_LAT-1]) begin
      err <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    logic [7:0]       mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] infl;
    logic             push;
    logic             pop;

    assign push = wb_v && (wb_id == ID_W'(i));
    assign pop  = res_valid[i] && res_ready[i];

    // Buffered plus in-flight results must fit, so a push never overflows.
    assign elig[i] = req_valid[i] &&
                     ((SUM_W'(cnt) + SUM_W'(infl)) < SUM_W'(OUT_DEPTH));

    assign res_valid[i]       = (cnt != '0);
    assign res_data[8*i +: 8] = mem[rd_ptr];

    // Result storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cvt_dout;
    end

    // FIFO pointers, occupancy and in-flight credit bookkeeping.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        infl   <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (!push && pop) cnt <= cnt - 1'b1;
        if (grant[i] && !push)      infl <= infl + 1'b1;
        else if (!grant[i] && push) infl <= infl - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f2i_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_f2i_share_arbiter
// Description : Scoreboard bench for f2i_share_arbiter with a one-cycle
//               behavioural converter. Accepted requests push their
//               hand-computed int8 into a per-lane queue; a monitor pops and
//               compares on every res_valid & res_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f2i_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            nrst;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [31:0]     cvt_din;
  logic            cvt_din_valid;
  logic [7:0]      cvt_dout = 8'h00;
  logic            cvt_dout_valid = 1'b0;
  logic [N*8-1:0]  res_data;
  logic [N-1:0]    res_valid;
  logic [N-1:0]    res_ready;
  logic            err;
  logic            inject;

  logic [7:0]      exp_byte [N];
  logic [7:0]      exp_q [N][$];
  logic [7:0]      exp_b;
  int              total = 0;
  int              bad   = 0;
  int              n2;
  int              nall;

  f2i_share_arbiter #(.N_REQ(N), .CVT_LAT(1), .OUT_DEPTH(2)) dut (
    .clk(clk), .nrst(nrst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .cvt_din(cvt_din), .cvt_din_valid(cvt_din_valid),
    .cvt_dout(cvt_dout), .cvt_dout_valid(cvt_dout_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  // Truncating, saturating float -> int8 used by the converter stand-in.
  function automatic logic [7:0] f2i(input logic [31:0] f);
    int e;
    int m;
    int v;
    e = int'(f[30:23]) - 127;
    if (e < 0) v = 0;
    else if (e > 7) v = f[31] ? -128 : 127;
    else begin
      m = int'({1'b1, f[22:0]});
      v = m >>> (23 - e);
      if (f[31]) v = -v;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
    end
    return v[7:0];
  endfunction

  // One-cycle converter; inject forces a strobe with nothing issued.
  always @(posedge clk) begin
    cvt_dout_valid <= cvt_din_valid | inject;
    cvt_dout       <= f2i(cvt_din);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] f, input logic [7:0] e);
    req_data[i*32 +: 32] = f;
    exp_byte[i]          = e;
  endtask

  // Scoreboard: pop/compare delivered results, then record new accepts.
  always @(negedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL lane%0d_unexpected: got=%02h want=none", i, res_data[8*i +: 8]);
          end else begin
            exp_b = exp_q[i].pop_front();
            check($sformatf("lane%0d_data", i), 32'(res_data[8*i +: 8]), 32'(exp_b));
          end
        end
        if (req_valid[i] && req_ready[i]) exp_q[i].push_back(exp_byte[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

  initial begin
    nrst      = 1'b0;
    inject    = 1'b0;
    req_data  = '0;
    req_valid = '1;
    res_ready = '1;
    set_lane(0, 32'h3F80_0000, 8'h01);  //   1.0
    set_lane(1, 32'hC000_0000, 8'hFE);  //  -2.0
    set_lane(2, 32'h42C8_0000, 8'h64);  // 100.0
    set_lane(3, 32'h40A0_0000, 8'h05);  //   5.0

    // Reset state, with requests pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_din_valid", 32'(cvt_din_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    next();
    req_valid = '0;
    nrst      = 1'b1;

    // Single lane: accept, then visible two cycles later.
    for (int v = 0; v < 3; v++) begin
      case (v)
        0:       set_lane(0, 32'h3F80_0000, 8'h01);
        1:       set_lane(0, 32'hC000_0000, 8'hFE);
        default: set_lane(0, 32'h42C8_0000, 8'h64);
      endcase
      req_valid = 4'b0001;
      @(negedge clk);
      check("single_grant", 32'(req_ready), 32'h1);
      check("single_din_valid", 32'(cvt_din_valid), 32'h1);
      check("single_din", cvt_din, req_data[31:0]);
      next();
      req_valid = '0;
      @(negedge clk);
      check("single_lat1_empty", 32'(res_valid[0]), 32'h0);
      next();
      @(negedge clk);
      check("single_lat2_valid", 32'(res_valid[0]), 32'h1);
      next();
    end

    set_lane(0, 32'h3F80_0000, 8'h01);
    set_lane(1, 32'hC000_0000, 8'hFE);
    set_lane(2, 32'h42C8_0000, 8'h64);
    set_lane(3, 32'h40A0_0000, 8'h05);

`ifndef F2I_ARB_PRIO0_EN
    // Round-robin: pointer sits at 1 after the lane-0 grants above.
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << ((1 + k) % 4)));
      next();
    end
    req_valid = '0;
    repeat (4) next();

    // Credit stall: lane 2 not drained gets exactly two accepts.
    res_ready = 4'b1011;
    req_valid = 4'b1111;
    n2   = 0;
    nall = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready[2]) n2++;
      if (|req_ready) nall++;
      next();
    end
    check("stall_lane2_accepts", 32'(n2), 32'd2);
    check("stall_grants_every_cycle", 32'(nall), 32'd12);
    req_valid = 4'b0100;
    res_ready = 4'b1111;
    @(negedge clk);
    check("stall_blocked", 32'(req_ready), 32'h0);
    check("stall_res_valid", 32'(res_valid[2]), 32'h1);
    next();
    res_ready = 4'b1011;
    @(negedge clk);
    check("stall_released", 32'(req_ready), 32'h4);
    next();
    req_valid = '0;
    res_ready = '1;
    repeat (6) next();
`else
    // Strict priority: lane 0 wins whenever it has credit (2 of 3 cycles
    // with a 2-deep FIFO), lane 3 only fills the gaps.
    req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("prio_grant%0d", k), 32'(req_ready), (k % 3 == 2) ? 32'h8 : 32'h1);
      next();
    end
    req_valid = 4'b1000;
    @(negedge clk);
    check("prio_lane3_after", 32'(req_ready), 32'h8);
    next();
    req_valid = '0;
    repeat (6) next();
`endif

    // Simultaneous push and pop on lane 1.
    res_ready = 4'b1101;
    set_lane(1, 32'h3F80_0000, 8'h01);
    req_valid = 4'b0010;
    @(negedge clk);
    check("pp_grant_a", 32'(req_ready), 32'h2);
    next();
    req_valid = '0;
    next();
    set_lane(1, 32'hC000_0000, 8'hFE);
    req_valid = 4'b0010;
    @(negedge clk);
    check("pp_grant_b", 32'(req_ready), 32'h2);
    check("pp_holding_one", 32'(res_valid[1]), 32'h1);
    next();
    req_valid = '0;
    res_ready = '1;
    next();
    @(negedge clk);
    check("pp_count_kept", 32'(res_valid[1]), 32'h1);
    next();
    @(negedge clk);
    check("pp_drained", 32'(res_valid[1]), 32'h0);
    next();

    // Spurious converter strobe sets a sticky error.
    inject = 1'b1;
    @(negedge clk);
    check("err_before", 32'(err), 32'h0);
    next();
    inject = 1'b0;
    next();
    @(negedge clk);
    check("err_set", 32'(err), 32'h1);
    repeat (3) next();
    @(negedge clk);
    check("err_sticky", 32'(err), 32'h1);

    // Reset in the middle of a burst with results buffered.
    next();
    res_ready = '0;
    req_valid = 4'b1111;
    repeat (3) next();
    @(negedge clk);
    check("burst_buffered", 32'(|res_valid), 32'h1);
    next();
    nrst = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    check("mid_rst_din_valid", 32'(cvt_din_valid), 32'h0);
    req_valid = '0;
    res_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    // Resume after reset.
    set_lane(3, 32'h40A0_0000, 8'h05);
    req_valid = 4'b1000;
    @(negedge clk);
    check("resume_grant", 32'(req_ready), 32'h8);
    next();
    req_valid = '0;
    repeat (4) next();
    @(negedge clk);
    check("resume_err_clear", 32'(err), 32'h0);
    for (int i = 0; i < N; i++)
      check($sformatf("lane%0d_queue_empty", i), 32'(exp_q[i].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
